// File: rtl/latency_catch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// latency_catch_pkg
//   Shared sizing helpers for the latency catch buffer and its catch FIFO.
//   - lcb_ptr_width / lcb_cnt_width : pointer and occupancy widths from DEPTH
//   - lcb_min_depth                 : smallest DEPTH giving 1 item/cycle
//   - lcb_params_ok                 : elaboration-time parameter legality
// -----------------------------------------------------------------------------
package latency_catch_pkg;

  // Minimum pipeline latency the credit scheme supports.
  localparam int unsigned LCB_LATENCY_MIN = 32'd1;

  // Extra FIFO entry beyond LATENCY needed so a pop and an issue can overlap.
  localparam int unsigned LCB_MIN_DEPTH_SLACK = 32'd1;

  // Read/write pointer width; pointers wrap naturally on a power-of-two DEPTH.
  function automatic int unsigned lcb_ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy/credit width: one extra bit so the value DEPTH is representable.
  function automatic int unsigned lcb_cnt_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

  // Smallest DEPTH that sustains full throughput for a given latency.
  function automatic int unsigned lcb_min_depth(input int unsigned latency);
    return latency + LCB_MIN_DEPTH_SLACK;
  endfunction

  // True when depth is a power of two of at least 2.
  function automatic bit lcb_is_pow2(input int unsigned depth);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

  // Combined legality check used by the elaboration assertions in the top.
  function automatic bit lcb_params_ok(input int unsigned depth,
                                       input int unsigned latency);
    return lcb_is_pow2(depth) && (latency >= LCB_LATENCY_MIN);
  endfunction

endpackage : latency_catch_pkg

// File: rtl/latency_catch_buffer_catch_fifo.sv
// -----------------------------------------------------------------------------
// catch_fifo
//   Synchronous show-ahead FIFO that catches results returning from a
//   fixed-latency pipeline. The head entry is visible on rd_data_o whenever
//   the FIFO is not empty; rd_en_i consumes it. A write into a full FIFO is
//   dropped (pointers unchanged) and flagged on overflow_o for that cycle.
//
// Ports
//   clk_i, rst_n_i  clock (rising edge), asynchronous active-low reset
//   wr_en_i         write strobe
//   wr_data_i       write data
//   rd_en_i         consume head (ignored when empty)
//   rd_data_o       head data
//   empty_o/full_o  status flags
//   count_o         occupancy, 0..DEPTH
//   overflow_o      write attempted while full (combinational pulse)
// -----------------------------------------------------------------------------
module catch_fifo
  import latency_catch_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32'd16,
  parameter  int unsigned DEPTH      = 32'd8,
  localparam int unsigned PW         = lcb_ptr_width(DEPTH),
  localparam int unsigned CW         = lcb_cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_fire_s;
  logic                  rd_fire_s;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DEPTH_C);
  assign count_o    = count_q;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign overflow_o = wr_en_i & full_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_fire_s = wr_en_i & ~full_o;
    rd_fire_s = rd_en_i & ~empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (wr_fire_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule : catch_fifo

// File: rtl/latency_catch_buffer.sv
// -----------------------------------------------------------------------------
// latency_catch_buffer
//   Receiving end of a fixed-latency, non-stallable pipeline. Work is issued
//   only while a credit (a free FIFO slot not yet claimed by an in-flight
//   item) is held; results are caught LATENCY cycles later into catch_fifo and
//   offered downstream with valid/ready.
//
//   Optional feature macro: LATENCY_CHECK_EN
//     defined   - a LATENCY-deep pipe of issue bits predicts ret_valid_i; any
//                 disagreement sets err_o (as does FIFO overflow)
//     undefined - err_o is set by FIFO overflow only
//
// Ports
//   clk_i, rst_n_i  clock (rising edge), asynchronous active-low reset
//   up_valid_i      upstream work item present
//   up_ready_o      credit available (outstanding < DEPTH)
//   issue_o         launch strobe into the pipeline (up_valid_i & up_ready_o)
//   ret_valid_i     pipeline result valid
//   ret_data_i      pipeline result
//   dn_valid_o      FIFO head valid
//   dn_data_o       FIFO head data, held while not accepted
//   dn_ready_i      downstream accepts head
//   credit_o        free credits (DEPTH - outstanding)
//   err_o           sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module latency_catch_buffer
  import latency_catch_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32'd16,
  parameter  int unsigned LATENCY    = 32'd4,
  parameter  int unsigned DEPTH      = 32'd8,
  localparam int unsigned CW         = lcb_cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  output logic                  issue_o,
  input  logic                  ret_valid_i,
  input  logic [DATA_WIDTH-1:0] ret_data_i,
  output logic                  dn_valid_o,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  input  logic                  dn_ready_i,
  output logic [CW-1:0]         credit_o,
  output logic                  err_o
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam int unsigned   MIN_DEPTH = lcb_min_depth(LATENCY);

  // Elaboration-time parameter checks.
  if (!lcb_params_ok(DEPTH, LATENCY)) begin : g_bad_params
    $error("latency_catch_buffer: DEPTH must be a power of two >= 2 and LATENCY >= 1");
  end
  if (DEPTH < MIN_DEPTH) begin : g_low_depth
    $warning("latency_catch_buffer: DEPTH < LATENCY+1, throughput below 1 item/cycle");
  end

  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  err_q, err_d;
  logic                  issue_s;
  logic                  pop_s;
  logic                  mismatch_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic                  overflow_s;
  logic [CW-1:0]         occupancy_s;
  logic [DATA_WIDTH-1:0] head_data_s;

  assign up_ready_o = (outstanding_q < DEPTH_C);
  assign issue_s    = up_valid_i & up_ready_o;
  assign issue_o    = issue_s;
  assign dn_valid_o = (occupancy_s != '0);
  assign dn_data_o  = head_data_s;
  // The empty term is redundant with dn_valid_o but keeps the pop
  // self-evidently safe against an empty FIFO.
  assign pop_s      = dn_ready_i & ~fifo_empty_s;
  assign credit_o   = DEPTH_C - outstanding_q;
  assign err_o      = err_q;

  catch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_catch_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (ret_valid_i),
    .wr_data_i  (ret_data_i),
    .rd_en_i    (pop_s),
    .rd_data_o  (head_data_s),
    .empty_o    (fifo_empty_s),
    .full_o     (fifo_full_s),
    .count_o    (occupancy_s),
    .overflow_o (overflow_s)
  );

`ifdef LATENCY_CHECK_EN
  logic [LATENCY-1:0] chk_pipe_q, chk_pipe_d;

  // Shift issue bits toward the slot that should line up with ret_valid_i.
  always_comb begin
    chk_pipe_d = (chk_pipe_q << 1) | LATENCY'(issue_s);
  end

  // Issue prediction pipe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chk_pipe_q <= '0;
    end else begin
      chk_pipe_q <= chk_pipe_d;
    end
  end

  assign mismatch_s = ret_valid_i ^ chk_pipe_q[LATENCY-1];
`else
  assign mismatch_s = 1'b0;
`endif

  // Credit accounting; the decrement floors at zero so results surviving a
  // mid-flight reset cannot wrap the count when popped.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({issue_s, pop_s})
      2'b10: outstanding_d = outstanding_q + CNT_ONE;
      2'b01: begin
        if (outstanding_q != '0) begin
          outstanding_d = outstanding_q - CNT_ONE;
        end else begin
          outstanding_d = outstanding_q;
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sticky error accumulation.
  always_comb begin
    err_d = err_q | overflow_s | mismatch_s;
  end

  // Credit counter and error flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // Full status is only consumed by the FIFO itself; tie it off visibly.
  logic unused_full_s;
  assign unused_full_s = fifo_full_s;

endmodule : latency_catch_buffer

// File: tb/tb_latency_catch_buffer.sv
// Self-checking bench for latency_catch_buffer (DATA_WIDTH=16, LATENCY=4,
// DEPTH=8). A behavioural pipeline model returns issued items LATENCY cycles
// later; a scoreboard queue holds the results the FIFO should present.
module tb_latency_catch_buffer;

  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam int DEP = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          up_valid_i;
  logic          up_ready_o;
  logic          issue_o;
  logic          ret_valid_i;
  logic [DW-1:0] ret_data_i;
  logic          dn_valid_o;
  logic [DW-1:0] dn_data_o;
  logic          dn_ready_i;
  logic [3:0]    credit_o;
  logic          err_o;

  latency_catch_buffer #(
    .DATA_WIDTH (DW),
    .LATENCY    (LAT),
    .DEPTH      (DEP)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .issue_o     (issue_o),
    .ret_valid_i (ret_valid_i),
    .ret_data_i  (ret_data_i),
    .dn_valid_o  (dn_valid_o),
    .dn_data_o   (dn_data_o),
    .dn_ready_i  (dn_ready_i),
    .credit_o    (credit_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state.
  int            tb_out;
  int            tb_occ;
  logic          tb_err;
  logic          ipipe [LAT];
  logic          mv    [LAT];
  logic [DW-1:0] md    [LAT];
  logic [DW-1:0] exp_q [$];
  logic          model_en;
  logic          man_v;
  logic [DW-1:0] man_d;
  logic [DW-1:0] issue_data;
  int            dut_issues;
  int            dut_pops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    tb_out = 0;
    tb_occ = 0;
    tb_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < LAT; i++) ipipe[i] = 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model over the
  // rising edge and drive the next pipeline return 1 ns later.
  task automatic step();
    logic          exp_ready, exp_issue, exp_dv, pop, cur_v, wr;
    logic [DW-1:0] cur_d;
    @(negedge clk_i);
    exp_ready = (tb_out < DEP);
    exp_issue = up_valid_i & exp_ready;
    exp_dv    = (tb_occ != 0);
    pop       = exp_dv & dn_ready_i;
    check("up_ready", up_ready_o, exp_ready);
    check("issue", issue_o, exp_issue);
    check("dn_valid", dn_valid_o, exp_dv);
    check("credit", credit_o, DEP - tb_out);
    check("err", err_o, tb_err);
    if (exp_dv) check("dn_data", dn_data_o, exp_q[0]);
    if (!rst_n_i) check("rst_dn_data", dn_data_o, 0);
    if (issue_o === 1'b1) dut_issues++;
    if (dn_valid_o === 1'b1 && dn_ready_i) dut_pops++;
    cur_v = ret_valid_i;
    cur_d = ret_data_i;
    @(posedge clk_i);
    if (rst_n_i) begin
      wr = cur_v && (tb_occ < DEP);
      if (cur_v && !wr) tb_err = 1'b1;
`ifdef LATENCY_CHECK_EN
      if (cur_v !== ipipe[LAT-1]) tb_err = 1'b1;
`endif
      if (pop) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(cur_d);
      tb_occ = tb_occ + (wr ? 1 : 0) - (pop ? 1 : 0);
      if (exp_issue && !pop) tb_out++;
      else if (!exp_issue && pop && tb_out > 0) tb_out--;
      for (int i = LAT - 1; i > 0; i--) ipipe[i] = ipipe[i-1];
      ipipe[0] = exp_issue;
    end
    // The pipeline itself is not reset and never stalls.
    for (int i = LAT - 1; i > 0; i--) begin
      mv[i] = mv[i-1];
      md[i] = md[i-1];
    end
    mv[0] = model_en & exp_issue & rst_n_i;
    md[0] = issue_data;
    if (mv[0]) issue_data = issue_data + 16'd1;
    #1;
    ret_valid_i = model_en ? mv[LAT-1] : man_v;
    ret_data_i  = model_en ? md[LAT-1] : man_d;
  endtask

  initial begin
    int lat, n, base_iss, base_pop;
    logic exp_err;
`ifdef LATENCY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n_i    = 1'b1;
    up_valid_i = 1'b0;
    ret_valid_i = 1'b0;
    ret_data_i = '0;
    dn_ready_i = 1'b0;
    model_en   = 1'b1;
    man_v      = 1'b0;
    man_d      = '0;
    issue_data = 16'h00A5;
    dut_issues = 0;
    dut_pops   = 0;
    for (int i = 0; i < LAT; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    clear_model();

    // Reset values.
    #2 rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;

    // Single item 0x00A5.
    dn_ready_i = 1'b1;
    up_valid_i = 1'b1;
    step();
    up_valid_i = 1'b0;
    lat = 0;
    while (dn_valid_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    // Counted from the issue edge: valid after LATENCY further edges.
    check("first_latency", lat, LAT);
    check("single_data", dn_data_o, 16'h00A5);
    repeat (3) step();
    check("single_credit", credit_o, DEP);

    // Streaming 32 items.
    issue_data = 16'h1000;
    base_iss = dut_issues;
    base_pop = dut_pops;
    up_valid_i = 1'b1;
    n = 0;
    while ((dut_issues - base_iss) < 32 && n < 100) begin
      step();
      n++;
    end
    up_valid_i = 1'b0;
    check("stream_cycles", n, 32);
    repeat (10) step();
    check("stream_pops", dut_pops - base_pop, 32);
    check("stream_err", err_o, 1'b0);

    // Backpressure: fill all credits.
    issue_data = 16'h2000;
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    base_iss = dut_issues;
    repeat (14) step();
    check("bp_issues", dut_issues - base_iss, DEP);
    check("bp_credit", credit_o, 0);
    check("bp_ready", up_ready_o, 1'b0);
    check("bp_head", dn_data_o, 16'h2000);
    // Release: one pop frees a credit, then issue+pop hold outstanding at 7.
    dn_ready_i = 1'b1;
    base_pop = dut_pops;
    repeat (6) step();
    check("hold7_credit", credit_o, 1);
    check("hold7_ready", up_ready_o, 1'b1);
    repeat (6) step();
    up_valid_i = 1'b0;
    repeat (14) step();
    check("bp_drain_pops", dut_pops - base_pop, dut_issues - base_iss);
    check("bp_drain_credit", credit_o, DEP);

    // Result returned one cycle early.
    model_en = 1'b0;
    man_v = 1'b0;
    up_valid_i = 1'b1;
    step();
    up_valid_i = 1'b0;
    step();
    man_v = 1'b1;
    man_d = 16'h0BAD;
    step();
    man_v = 1'b0;
    step();
    step();
    repeat (4) step();
    check("early_err", err_o, exp_err);
    check("early_credit", credit_o, DEP);
    model_en = 1'b1;

    // Reset with three items in flight; their results return after release.
    clear_model();
    rst_n_i = 1'b0;
    #1 rst_n_i = 1'b1;
    issue_data = 16'h3000;
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    repeat (3) step();
    up_valid_i = 1'b0;
    rst_n_i = 1'b0;
    clear_model();
    step();
    rst_n_i = 1'b1;
    repeat (6) step();
    check("late_err", err_o, exp_err);
    check("late_head", dn_data_o, 16'h3000);
    dn_ready_i = 1'b1;
    repeat (5) step();
    check("late_credit", credit_o, DEP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_latency_catch_buffer
